// File: rtl/coded_lock_pkg.sv
// coded_lock_pkg
// Shared definitions for the coded lock and its key sender:
//   - button symbol encoding (2 bits per symbol)
//   - key sender FSM state enum
//   - small constant helpers used to size counters and decode symbols
package coded_lock_pkg;

    localparam logic [1:0] SYM_Q = 2'b00;
    localparam logic [1:0] SYM_U = 2'b01;
    localparam logic [1:0] SYM_N = 2'b10;
    localparam logic [1:0] SYM_B = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRESS = 3'd1,
        ST_GAP   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } key_state_t;

    // Largest of three positive constants; sizes the shared timer.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Symbol to one-hot button vector, ordered {b, n, u, q}.
    function automatic logic [3:0] sym_onehot(input logic [1:0] s);
        logic [3:0] v;
        v = 4'b0000;
        case (s)
            SYM_Q:   v = 4'b0001;
            SYM_U:   v = 4'b0010;
            SYM_N:   v = 4'b0100;
            default: v = 4'b1000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/coded_key_timer.sv
// coded_key_timer
// Loadable saturating up-counter shared by the PRESS, GAP and WAIT phases.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   load        restart the count at 0 (used on every state change)
//   limit       terminal count for the current phase
//   tc          high while the count equals limit
module coded_key_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] count;

    // Saturates at limit so it can never wrap while the FSM lingers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (count != limit) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == limit);

endmodule

// File: rtl/coded_key_sender.sv
// coded_key_sender
// Plays a stored button code into a coded_lock as timed one-hot presses,
// then waits for the lock's LEDs and reports the verdict.
// Ports:
//   clk, rst_n     clock / asynchronous active-low reset
//   start          send request, sampled only in IDLE
//   code           symbol k at code[2k+1:2k], symbol 0 sent first
//   q, u, n, b     registered button drives, at most one high
//   led1, led2     lock open / lock error indicators
//   busy           high from the cycle after start acceptance through DONE
//   done           one-cycle verdict pulse
//   pass, fail     sticky verdict flags, cleared on the next accepted start
//   timeout        sticky, qualifies fail as "no response"
//   dbg_state      current FSM state (key_state_t encoding)
//
// Handshake: start is a level request; it is taken only on a cycle where the
// FSM is in IDLE, and is ignored otherwise. done/pass/fail/timeout all become
// valid in the same cycle; no acknowledge is required.
module coded_key_sender
    import coded_lock_pkg::*;
#(
    parameter int CODE_LEN       = 4,
    parameter int PRESS_CYCLES   = 4,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2*CODE_LEN-1:0] code,
    output logic                  q,
    output logic                  u,
    output logic                  n,
    output logic                  b,
    input  logic                  led1,
    input  logic                  led2,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic                  timeout,
    output logic [2:0]            dbg_state
);

    localparam int CW = $clog2(max3(PRESS_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES) + 1);
    localparam int IW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

    localparam logic [CW-1:0] PRESS_LIM = CW'(PRESS_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LIM   = CW'(GAP_CYCLES - 1);
    // WAIT lasts TIMEOUT_CYCLES+1 cycles: counts 0..TIMEOUT_CYCLES inclusive.
    localparam logic [CW-1:0] WAIT_LIM  = CW'(TIMEOUT_CYCLES);
    localparam logic [IW-1:0] LAST_IDX  = IW'(CODE_LEN - 1);

    key_state_t            state, next_state;
    logic [IW-1:0]         idx, idx_next;
    logic [2*CODE_LEN-1:0] code_r, code_next;
    logic [CW-1:0]         limit;
    logic                  tc;
    logic                  load;
    logic                  accept;
    logic                  set_pass, set_fail, set_to;
    logic [3:0]            btn_next;

    coded_key_timer #(.W(CW)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .limit (limit),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        idx_next   = idx;
        code_next  = code_r;
        accept     = 1'b0;
        set_pass   = 1'b0;
        set_fail   = 1'b0;
        set_to     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    code_next  = code;
                    idx_next   = '0;
                    next_state = ST_PRESS;
                end
            end
            ST_PRESS: begin
                if (led2) begin
                    set_fail   = 1'b1;
                    next_state = ST_DONE;
                end else if (tc) begin
                    next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                if (led2) begin
                    set_fail   = 1'b1;
                    next_state = ST_DONE;
                end else if (tc) begin
                    if (idx == LAST_IDX) begin
                        next_state = ST_WAIT;
                    end else begin
                        idx_next   = idx + 1'b1;
                        next_state = ST_PRESS;
                    end
                end
            end
            ST_WAIT: begin
                // led2 wins over led1 when both arrive together.
                if (led2) begin
                    set_fail   = 1'b1;
                    next_state = ST_DONE;
                end else if (led1) begin
                    set_pass   = 1'b1;
                    next_state = ST_DONE;
                end else if (tc) begin
                    set_fail   = 1'b1;
                    set_to     = 1'b1;
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        limit = '0;
        case (state)
            ST_PRESS: limit = PRESS_LIM;
            ST_GAP:   limit = GAP_LIM;
            ST_WAIT:  limit = WAIT_LIM;
            default:  limit = '0;
        endcase
    end

    // Every phase starts timing from 0 on entry.
    assign load = (next_state != state);

    // Buttons are registered from the next-state decode so the first press
    // appears in the cycle right after start is accepted.
    always_comb begin
        btn_next = 4'b0000;
        if (next_state == ST_PRESS) begin
            btn_next = sym_onehot(code_next[2*int'(idx_next) +: 2]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            code_r       <= '0;
            {b, n, u, q} <= 4'b0000;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            idx          <= idx_next;
            code_r       <= code_next;
            {b, n, u, q} <= btn_next;
            busy         <= (next_state != ST_IDLE);
            done         <= (next_state == ST_DONE);
            if (accept) begin
                pass    <= 1'b0;
                fail    <= 1'b0;
                timeout <= 1'b0;
            end else begin
                pass    <= pass | set_pass;
                fail    <= fail | set_fail;
                timeout <= timeout | set_to;
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_coded_key_sender.sv
// tb_coded_key_sender
// Directed bench for coded_key_sender with default parameters
// (CODE_LEN=4, P=G=4, TIMEOUT=64). Cycle numbering: the cycle in which start
// is high is cycle 0; outputs are observed 1 time unit after each rising edge.
module tb_coded_key_sender;
    import coded_lock_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] code;
    logic       q, u, n, b;
    logic       led1, led2;
    logic       busy, done, pass, fail, timeout;
    logic [2:0] dbg_state;
    logic [3:0] btn;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign btn = {b, n, u, q};

    coded_key_sender #(
        .CODE_LEN       (4),
        .PRESS_CYCLES   (4),
        .GAP_CYCLES     (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .code      (code),
        .q         (q),
        .u         (u),
        .n         (n),
        .b         (b),
        .led1      (led1),
        .led2      (led2),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail      (fail),
        .timeout   (timeout),
        .dbg_state (dbg_state)
    );

    // Expected {b,n,u,q} in cycle cyc after start: symbol k is pressed in
    // cycles 1+8k .. 8k+4, everything else is low.
    function automatic logic [3:0] exp_btn(input logic [7:0] c, input int cyc);
        int k, off;
        logic [1:0] s;
        if (cyc < 1 || cyc > 32) return 4'b0000;
        k   = (cyc - 1) / 8;
        off = (cyc - 1) % 8;
        if (off >= 4) return 4'b0000;
        s = c[2*k +: 2];
        return 4'b0001 << s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Call 1 unit after an edge with the DUT in IDLE; returns in cycle 1.
    task automatic do_start(input logic [7:0] c);
        start = 1'b1;
        code  = c;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        code  = 8'h00;
        led1  = 1'b0;
        led2  = 1'b0;
        step();
        step();
        n_cmp++;
        if ({q, u, n, b, busy, done, pass, fail, timeout} !== 9'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 000000000",
                     {q, u, n, b, busy, done, pass, fail, timeout});
        end
        n_cmp++;
        if (dbg_state !== 3'd0) begin
            n_err++;
            $display("FAIL reset_state: got %0d want 0", dbg_state);
        end
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_sequence();
        logic [7:0] c;
        c = 8'b11_10_01_00;
        do_start(c);
        for (int cyc = 1; cyc <= 35; cyc++) begin
            n_cmp++;
            if (btn !== exp_btn(c, cyc)) begin
                n_err++;
                $display("FAIL seq_btn c%0d: got %b want %b", cyc, btn, exp_btn(c, cyc));
            end
            n_cmp++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_err++;
                $display("FAIL seq_busy_done c%0d: got %b%b want 10", cyc, busy, done);
            end
            if (cyc == 33) begin
                n_cmp++;
                if (dbg_state !== 3'(ST_WAIT)) begin
                    n_err++;
                    $display("FAIL seq_wait_entry: got %0d want %0d", dbg_state, ST_WAIT);
                end
            end
            step();
        end
        led1 = 1'b1;   // cycle 36 = WAIT entry + 3
        step();
        led1 = 1'b0;
        n_cmp++;
        if ({done, pass, fail, timeout, busy} !== 5'b11001) begin
            n_err++;
            $display("FAIL seq_verdict: got done,pass,fail,to,busy=%b want 11001",
                     {done, pass, fail, timeout, busy});
        end
        step();
        n_cmp++;
        if ({done, busy, pass} !== 3'b001) begin
            n_err++;
            $display("FAIL seq_after: got done,busy,pass=%b want 001", {done, busy, pass});
        end
    endtask

    task automatic test_abort();
        int dcnt;
        do_start(8'b11_10_01_00);
        n_cmp++;
        if (pass !== 1'b0) begin
            n_err++;
            $display("FAIL abort_flags_cleared: got pass=%b want 0", pass);
        end
        repeat (17) step();   // cycle 18: inside third press
        n_cmp++;
        if (btn !== 4'b0100) begin
            n_err++;
            $display("FAIL abort_third_press: got %b want 0100", btn);
        end
        led2 = 1'b1;
        step();
        led2 = 1'b0;
        n_cmp++;
        if ({btn, done, pass, fail, timeout} !== 8'b0000_1010) begin
            n_err++;
            $display("FAIL abort_verdict: got btn,done,pass,fail,to=%b want 00001010",
                     {btn, done, pass, fail, timeout});
        end
        dcnt = 0;
        repeat (6) begin
            step();
            if (done) dcnt++;
        end
        n_cmp++;
        if (dcnt !== 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_single_done: got extra=%0d busy=%b want 0 0", dcnt, busy);
        end
    endtask

    task automatic test_timeout();
        int dcnt;
        do_start(8'b00_11_10_01);
        dcnt = 0;
        for (int cyc = 1; cyc <= 97; cyc++) begin
            if (done) dcnt++;
            step();
        end
        n_cmp++;
        if (dcnt !== 0) begin
            n_err++;
            $display("FAIL timeout_early_done: got %0d pulses want 0", dcnt);
        end
        // cycle 98 = WAIT entry (33) + 65
        n_cmp++;
        if ({done, pass, fail, timeout} !== 4'b1011) begin
            n_err++;
            $display("FAIL timeout_verdict: got done,pass,fail,to=%b want 1011",
                     {done, pass, fail, timeout});
        end
        step();
        n_cmp++;
        if ({done, busy, fail, timeout} !== 4'b0011) begin
            n_err++;
            $display("FAIL timeout_after: got done,busy,fail,to=%b want 0011",
                     {done, busy, fail, timeout});
        end
    endtask

    task automatic test_both_leds();
        do_start(8'b11_10_01_00);
        repeat (33) step();   // cycle 34, in WAIT
        led1 = 1'b1;
        led2 = 1'b1;
        step();
        led1 = 1'b0;
        led2 = 1'b0;
        n_cmp++;
        if ({done, pass, fail, timeout} !== 4'b1010) begin
            n_err++;
            $display("FAIL both_leds: got done,pass,fail,to=%b want 1010",
                     {done, pass, fail, timeout});
        end
        step();
    endtask

    task automatic test_ignore_start();
        logic [7:0] c;
        int dcnt;
        c = 8'b00_01_10_11;
        do_start(c);
        dcnt = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc <= 32) begin
                n_cmp++;
                if (btn !== exp_btn(c, cyc)) begin
                    n_err++;
                    $display("FAIL ignore_btn c%0d: got %b want %b", cyc, btn, exp_btn(c, cyc));
                end
            end
            if (done) dcnt++;
            start = (cyc == 5);
            if (cyc == 5) code = 8'b01_01_01_01;
            led1 = (cyc == 33);
            step();
        end
        n_cmp++;
        if (dcnt !== 1 || pass !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_single_done: got done=%0d pass=%b busy=%b want 1 1 0",
                     dcnt, pass, busy);
        end
    endtask

    task automatic test_back_to_back();
        do_start(8'b11_10_01_00);
        repeat (32) step();   // cycle 33
        led1 = 1'b1;
        step();
        led1 = 1'b0;
        n_cmp++;
        if ({done, pass} !== 2'b11) begin
            n_err++;
            $display("FAIL b2b_first_verdict: got done,pass=%b want 11", {done, pass});
        end
        step();               // first IDLE cycle
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle: got busy=%b want 0", busy);
        end
        do_start(8'b01_01_01_01);
        n_cmp++;
        if ({busy, btn, pass} !== 6'b1_0010_0) begin
            n_err++;
            $display("FAIL b2b_accept: got busy,btn,pass=%b want 100100", {busy, btn, pass});
        end
        step();
        step();
        led2 = 1'b1;
        step();
        led2 = 1'b0;
        n_cmp++;
        if ({done, fail, btn} !== 6'b11_0000) begin
            n_err++;
            $display("FAIL b2b_abort: got done,fail,btn=%b want 110000", {done, fail, btn});
        end
        step();
    endtask

    task automatic test_reset_mid();
        logic [7:0] c;
        do_start(8'b11_10_01_00);
        repeat (21) step();   // cycle 22: gap after symbol 2
        n_cmp++;
        if (dbg_state !== 3'(ST_GAP) || busy !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_pre: got state=%0d busy=%b want %0d 1", dbg_state, busy, ST_GAP);
        end
        rst_n = 1'b0;
        #1;                   // no clock edge between here and the check
        n_cmp++;
        if ({q, u, n, b, busy, done, pass, fail, timeout, dbg_state} !== 12'b0) begin
            n_err++;
            $display("FAIL rstmid_async: got %b want 000000000000",
                     {q, u, n, b, busy, done, pass, fail, timeout, dbg_state});
        end
        step();
        rst_n = 1'b1;
        step();
        c = 8'b00_01_10_11;
        do_start(c);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            n_cmp++;
            if (btn !== exp_btn(c, cyc)) begin
                n_err++;
                $display("FAIL rstmid_replay c%0d: got %b want %b", cyc, btn, exp_btn(c, cyc));
            end
            if (cyc < 12) step();
        end
        led2 = 1'b1;
        step();
        led2 = 1'b0;
        n_cmp++;
        if ({done, fail, btn} !== 6'b11_0000) begin
            n_err++;
            $display("FAIL rstmid_abort: got done,fail,btn=%b want 110000", {done, fail, btn});
        end
        step();
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_abort();
        test_timeout();
        test_both_leds();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
